// File: rtl/vm_change_pkg.sv
// Shared types for the change dispenser: FSM states, coin selection and fault bit positions.
package vm_change_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SELECT   = 3'd1,
        PULSE    = 3'd2,
        WAIT_ACK = 3'd3,
        DONE     = 3'd4
    } state_t;

    typedef enum logic {
        COIN_SMALL = 1'b0,
        COIN_BIG   = 1'b1
    } coin_t;

    localparam int FAULT_BIG   = 1;
    localparam int FAULT_SMALL = 0;

endpackage

// File: rtl/vm_change_dispenser_if.sv
// Bundle between the vending FSM / hopper hardware (master) and the change dispenser (slave).
interface vm_change_dispenser_if #(
    parameter int VAL_W = 8
);
    // Request handshake: a request transfers on a clock edge where req_valid and req_ready are
    // both high; req_ready is high only while idle and nothing is queued; completion is the
    // one-cycle done strobe with shortfall valid in that cycle.
    logic                   req_valid;
    logic [VAL_W-1:0]       req_value;
    logic                   req_ready;
    logic                   big_pulse;
    logic                   big_ack;
    logic                   big_empty;
    logic                   small_pulse;
    logic                   small_ack;
    logic                   small_empty;
    logic                   busy;
    logic                   done;
    logic [VAL_W-1:0]       shortfall;
    logic [1:0]             fault;
    logic [15:0]            big_count;
    logic [15:0]            small_count;
    vm_change_pkg::state_t  dbg_state;

    modport master (
        output req_valid, req_value, big_ack, big_empty, small_ack, small_empty,
        input  req_ready, big_pulse, small_pulse, busy, done, shortfall, fault,
               big_count, small_count, dbg_state
    );

    modport slave (
        input  req_valid, req_value, big_ack, big_empty, small_ack, small_empty,
        output req_ready, big_pulse, small_pulse, busy, done, shortfall, fault,
               big_count, small_count, dbg_state
    );

endinterface

// File: rtl/vm_pulse_timer.sv
// Shared cycle counter: measures the eject pulse length and the ack timeout after a start.
module vm_pulse_timer #(
    parameter int PULSE_CYC   = 4,
    parameter int TIMEOUT_CYC = 1000,
    parameter int CNT_W       = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic pulse_active,
    output logic expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturates so a long stall never wraps back into the pulse window.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // pulse_active is low in the last pulse cycle; expired is high in the last wait cycle.
    assign pulse_active = (cnt_q < CNT_W'(PULSE_CYC - 1));
    assign expired      = (cnt_q >= CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/vm_change_dispenser.sv
// Greedy two-hopper change payout with per-coin pulse/ack, timeout and sticky faults.
// Define VM_CHANGE_STATS_EN to enable the per-hopper paid-coin counters.
module vm_change_dispenser
    import vm_change_pkg::*;
#(
    parameter int VAL_W       = 8,
    parameter int BIG_VAL     = 5,
    parameter int SMALL_VAL   = 1,
    parameter int PULSE_CYC   = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input logic                  clk,
    input logic                  rst,
    vm_change_dispenser_if.slave bus
);

    localparam int MAX_CYC = (PULSE_CYC > TIMEOUT_CYC) ? PULSE_CYC : TIMEOUT_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [VAL_W-1:0] BIG_V   = VAL_W'(BIG_VAL);
    localparam logic [VAL_W-1:0] SMALL_V = VAL_W'(SMALL_VAL);

    state_t           state_q;
    coin_t            sel_q;
    logic [VAL_W-1:0] rem_q;
    logic [VAL_W-1:0] shortfall_q;
    logic [1:0]       fault_q;
    logic             req_ready_q;
    logic             busy_q;
    logic             done_q;
    logic             big_pulse_q;
    logic             small_pulse_q;
    logic             ack_seen_q;

    logic             big_usable;
    logic             small_usable;
    logic             sel_ack;
    logic             last_pulse;
    logic             timer_start;
    logic             coin_paid;
    logic             pulse_active;
    logic             expired;
    logic [VAL_W-1:0] coin_val;

    always_comb begin
        big_usable   = !bus.big_empty && !fault_q[FAULT_BIG];
        small_usable = !bus.small_empty && !fault_q[FAULT_SMALL];
        sel_ack      = (sel_q == COIN_BIG) ? bus.big_ack : bus.small_ack;
        coin_val     = (sel_q == COIN_BIG) ? BIG_V : SMALL_V;
        last_pulse   = (state_q == PULSE) && !pulse_active;
        timer_start  = (state_q == SELECT) || last_pulse;
        // An ack captured during the pulse pays the coin at pulse end and skips WAIT_ACK.
        coin_paid    = (last_pulse && (ack_seen_q || sel_ack)) ||
                       ((state_q == WAIT_ACK) && sel_ack);
    end

    vm_pulse_timer #(
        .PULSE_CYC  (PULSE_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .CNT_W      (CNT_W)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .start       (timer_start),
        .pulse_active(pulse_active),
        .expired     (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            sel_q         <= COIN_SMALL;
            rem_q         <= '0;
            shortfall_q   <= '0;
            fault_q       <= '0;
            req_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            big_pulse_q   <= 1'b0;
            small_pulse_q <= 1'b0;
            ack_seen_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        rem_q       <= bus.req_value;
                        shortfall_q <= '0;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= SELECT;
                    end
                end
                SELECT: begin
                    ack_seen_q <= 1'b0;
                    if (rem_q != '0 && rem_q >= BIG_V && big_usable) begin
                        sel_q       <= COIN_BIG;
                        big_pulse_q <= 1'b1;
                        state_q     <= PULSE;
                    end else if (rem_q != '0 && rem_q >= SMALL_V && small_usable) begin
                        sel_q         <= COIN_SMALL;
                        small_pulse_q <= 1'b1;
                        state_q       <= PULSE;
                    end else begin
                        done_q      <= 1'b1;
                        shortfall_q <= rem_q;
                        state_q     <= DONE;
                    end
                end
                PULSE: begin
                    if (sel_ack) begin
                        ack_seen_q <= 1'b1;
                    end
                    if (last_pulse) begin
                        big_pulse_q   <= 1'b0;
                        small_pulse_q <= 1'b0;
                        if (coin_paid) begin
                            rem_q   <= rem_q - coin_val;
                            state_q <= SELECT;
                        end else begin
                            state_q <= WAIT_ACK;
                        end
                    end
                end
                WAIT_ACK: begin
                    if (coin_paid) begin
                        rem_q   <= rem_q - coin_val;
                        state_q <= SELECT;
                    end else if (expired) begin
                        if (sel_q == COIN_BIG) begin
                            fault_q[FAULT_BIG] <= 1'b1;
                        end else begin
                            fault_q[FAULT_SMALL] <= 1'b1;
                        end
                        state_q <= SELECT;
                    end
                end
                DONE: begin
                    req_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef VM_CHANGE_STATS_EN
    logic [15:0] big_count_q;
    logic [15:0] big_count_d;
    logic [15:0] small_count_q;
    logic [15:0] small_count_d;

    always_comb begin
        big_count_d   = big_count_q;
        small_count_d = small_count_q;
        if (coin_paid) begin
            if (sel_q == COIN_BIG) begin
                if (big_count_q != 16'hFFFF) big_count_d = big_count_q + 16'd1;
            end else begin
                if (small_count_q != 16'hFFFF) small_count_d = small_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            big_count_q   <= '0;
            small_count_q <= '0;
        end else begin
            big_count_q   <= big_count_d;
            small_count_q <= small_count_d;
        end
    end

    assign bus.big_count   = big_count_q;
    assign bus.small_count = small_count_q;
`else
    assign bus.big_count   = '0;
    assign bus.small_count = '0;
`endif

    assign bus.req_ready   = req_ready_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.shortfall   = shortfall_q;
    assign bus.fault       = fault_q;
    assign bus.big_pulse   = big_pulse_q;
    assign bus.small_pulse = small_pulse_q;
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Directed bench for vm_change_dispenser: hopper models, scoreboard of pulse/done events.
module tb_vm_change_dispenser;
    import vm_change_pkg::*;

    localparam int VAL_W       = 8;
    localparam int PULSE_CYC   = 4;
    localparam int TIMEOUT_CYC = 20;
    localparam int EW          = 12;   // event = {kind[1:0], shortfall[7:0], fault[1:0]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vm_change_dispenser_if #(.VAL_W(VAL_W)) bus ();

    vm_change_dispenser #(
        .VAL_W      (VAL_W),
        .BIG_VAL    (5),
        .SMALL_VAL  (1),
        .PULSE_CYC  (PULSE_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic big_ack_drv   = 1'b0;
    logic small_ack_drv = 1'b0;
    logic small_stray   = 1'b0;
    assign bus.big_ack   = big_ack_drv;
    assign bus.small_ack = small_ack_drv | small_stray;

    int big_ack_en    = 1;
    int big_ack_dly   = 6;
    int small_ack_en  = 1;
    int small_ack_dly = 6;

    int checks    = 0;
    int errors    = 0;
    int done_seen = 0;
    int exp_big   = 0;
    int exp_small = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_event(input logic [EW-1:0] act, input string name);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: got event 0x%0h expected none at %0t", name, act, $time);
        end else begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got event 0x%0h expected 0x%0h at %0t", name, act, e, $time);
            end
        end
    endtask

    // ---------------- hopper models ----------------
    initial forever begin
        @(posedge bus.big_pulse);
        if (big_ack_en != 0) begin
            repeat (big_ack_dly) @(posedge clk);
            #1 big_ack_drv = 1'b1;
            @(posedge clk);
            #1 big_ack_drv = 1'b0;
        end
    end

    initial forever begin
        @(posedge bus.small_pulse);
        if (small_ack_en != 0) begin
            repeat (small_ack_dly) @(posedge clk);
            #1 small_ack_drv = 1'b1;
            @(posedge clk);
            #1 small_ack_drv = 1'b0;
        end
    end

    // ---------------- monitor ----------------
    logic big_prev     = 1'b0;
    logic small_prev   = 1'b0;
    logic rst_in_pulse = 1'b0;
    int   pulse_len    = 0;

    always @(negedge clk) begin
        if (bus.big_pulse && !big_prev) check_event({2'd1, 8'd0, 2'd0}, "big_pulse_order");
        if (bus.small_pulse && !small_prev) check_event({2'd2, 8'd0, 2'd0}, "small_pulse_order");
        if (bus.big_pulse || bus.small_pulse) begin
            check("pulse_exclusive", 32'(bus.big_pulse & bus.small_pulse), 32'd0);
            pulse_len++;
            if (rst) rst_in_pulse = 1'b1;
        end else if (big_prev || small_prev) begin
            if (!rst_in_pulse) check("pulse_len", 32'(pulse_len), 32'(PULSE_CYC));
            pulse_len    = 0;
            rst_in_pulse = 1'b0;
        end
        if (bus.done) begin
            check_event({2'd3, bus.shortfall, bus.fault}, "done_result");
            done_seen++;
        end
        big_prev   = bus.big_pulse;
        small_prev = bus.small_pulse;
    end

    // ---------------- driver tasks ----------------
    task automatic push_coin(input bit big, input bit paid);
        exp_q.push_back({big ? 2'd1 : 2'd2, 8'd0, 2'd0});
        if (paid) begin
            if (big) exp_big++;
            else     exp_small++;
        end
    endtask

    task automatic push_done(input logic [7:0] sf, input logic [1:0] flt);
        exp_q.push_back({2'd3, sf, flt});
    endtask

    task automatic drive_req(input logic [7:0] v);
        int n;
        @(posedge clk);
        #1 bus.req_valid = 1'b1;
        bus.req_value = v;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("req_accepted", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic check_counts(input string name);
        int eb;
        int es;
`ifdef VM_CHANGE_STATS_EN
        eb = exp_big;
        es = exp_small;
`else
        eb = 0;
        es = 0;
`endif
        check({name, " big_count"}, 32'(bus.big_count), 32'(eb));
        check({name, " small_count"}, 32'(bus.small_count), 32'(es));
    endtask

    task automatic run_req(input string name, input logic [7:0] v);
        int d0;
        int n;
        d0 = done_seen;
        drive_req(v);
        n = 0;
        while (done_seen == d0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({name, " completes"}, 32'(done_seen != d0), 32'd1);
        @(negedge clk);
        check({name, " queue_drained"}, 32'(exp_q.size()), 32'd0);
        check_counts(name);
    endtask

    task automatic wait_big_rise(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.big_pulse && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, " big_pulse_seen"}, 32'(bus.big_pulse), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  k;
        bit  saw_wait;
        bus.req_valid   = 1'b0;
        bus.req_value   = '0;
        bus.big_empty   = 1'b0;
        bus.small_empty = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst req_ready", 32'(bus.req_ready), 32'd1);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst done", 32'(bus.done), 32'd0);
        check("rst big_pulse", 32'(bus.big_pulse), 32'd0);
        check("rst small_pulse", 32'(bus.small_pulse), 32'd0);
        check("rst fault", 32'(bus.fault), 32'd0);
        check("rst shortfall", 32'(bus.shortfall), 32'd0);
        check("rst state", 32'(bus.dbg_state), 32'(IDLE));
        check_counts("rst");

        // 13 = 5 + 5 + 1 + 1 + 1
        push_coin(1, 1); push_coin(1, 1);
        push_coin(0, 1); push_coin(0, 1); push_coin(0, 1);
        push_done(8'd0, 2'b00);
        run_req("greedy_13", 8'd13);

        // BIG hopper empty: all SMALL
        bus.big_empty = 1'b1;
        for (int i = 0; i < 7; i++) push_coin(0, 1);
        push_done(8'd0, 2'b00);
        run_req("big_empty_7", 8'd7);
        bus.big_empty = 1'b0;

        // SMALL never acks: one BIG paid, SMALL times out, 1 unit short
        small_ack_en = 0;
        push_coin(1, 1); push_coin(0, 0);
        push_done(8'd1, 2'b01);
        run_req("small_timeout_6", 8'd6);
        push_coin(1, 1);
        push_done(8'd0, 2'b01);
        run_req("avoid_small_5", 8'd5);
        push_done(8'd3, 2'b01);
        run_req("avoid_small_3", 8'd3);
        small_ack_en = 1;

        // zero request: done two cycles after accept, not ready meanwhile
        push_done(8'd0, 2'b01);
        drive_req(8'd0);
        @(negedge clk);
        check("zero c1 req_ready", 32'(bus.req_ready), 32'd0);
        check("zero c1 done", 32'(bus.done), 32'd0);
        @(negedge clk);
        check("zero c2 req_ready", 32'(bus.req_ready), 32'd0);
        check("zero c2 done", 32'(bus.done), 32'd1);
        @(negedge clk);
        check("zero c3 req_ready", 32'(bus.req_ready), 32'd1);
        check("zero c3 done", 32'(bus.done), 32'd0);
        check("zero queue_drained", 32'(exp_q.size()), 32'd0);

        // reset in the second cycle of a BIG pulse
        push_coin(1, 0);
        drive_req(8'd10);
        wait_big_rise("abort");
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_big   = 0;
        exp_small = 0;
        @(negedge clk);
        check("abort big_pulse", 32'(bus.big_pulse), 32'd0);
        check("abort req_ready", 32'(bus.req_ready), 32'd1);
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort fault", 32'(bus.fault), 32'd0);
        check("abort state", 32'(bus.dbg_state), 32'(IDLE));
        check_counts("abort");
        repeat (10) @(negedge clk);
        check("abort queue_drained", 32'(exp_q.size()), 32'd0);

        // ack during PULSE plus a stray SMALL ack: no WAIT_ACK dwell
        big_ack_dly = 2;
        push_coin(1, 1);
        push_done(8'd0, 2'b00);
        drive_req(8'd5);
        wait_big_rise("early_ack");
        @(posedge clk);
        #1 small_stray = 1'b1;
        @(posedge clk);
        #1 small_stray = 1'b0;
        k = 2;
        saw_wait = 1'b0;
        while (k < 100) begin
            @(negedge clk);
            if (bus.done) break;
            if (bus.dbg_state == WAIT_ACK) saw_wait = 1'b1;
            k++;
        end
        check("early_ack done_cycle", 32'(k), 32'd5);
        check("early_ack no_wait", 32'(saw_wait), 32'd0);
        @(negedge clk);
        check("early_ack queue_drained", 32'(exp_q.size()), 32'd0);
        check_counts("early_ack");

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vm_change_dispenser.md
Name: vm_change_dispenser

Overview:
- Sequences coin return for the vending machine: takes one change request (value in coin units) and drives two coin hoppers, BIG and SMALL, until the value is paid out or no hopper can pay.
- Uses greedy selection, a per-coin pulse/ack handshake with a timeout, and sticky per-hopper fault flags.
- Sits between the main vending FSM, which issues the request on cancel or after a purchase, and the hopper drivers and coin sensors.

Parameters:
- VAL_W, 8, width of value and remaining-amount paths
- BIG_VAL, 5, units paid per BIG coin
- SMALL_VAL, 1, units paid per SMALL coin
- PULSE_CYC, 4, cycles the hopper eject pulse stays high (>=1)
- TIMEOUT_CYC, 1000, max cycles in WAIT_ACK before a hopper is declared faulty

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  change request
- req_value  in  VAL_W  amount to return
- req_ready  out  1  high only in IDLE
- big_pulse  out  1  eject one BIG coin
- big_ack  in  1  single-cycle BIG coin-sensor pulse
- big_empty  in  1  BIG hopper empty
- small_pulse  out  1  eject one SMALL coin
- small_ack  in  1  single-cycle SMALL coin-sensor pulse
- small_empty  in  1  SMALL hopper empty
- busy  out  1  not in IDLE
- done  out  1  one-cycle completion strobe
- shortfall  out  VAL_W  unpaid remainder, valid while done=1, held until next accept
- fault  out  2  sticky; bit1 = BIG timed out, bit0 = SMALL timed out
- big_count  out  16  BIG coins paid (optional feature)
- small_count  out  16  SMALL coins paid (optional feature)

Behaviour:
- Reset values: all outputs 0 except req_ready=1; state IDLE; remaining=0; timers=0; fault=0. A reset mid-operation aborts immediately; any pulse drops the next cycle.
- IDLE: when req_valid and req_ready, latch remaining=req_value and go to SELECT. req_valid is ignored in every other state, so no request is queued.
- SELECT (1 cycle):
  - remaining==0 → DONE.
  - Otherwise, if remaining>=BIG_VAL and BIG usable → select BIG, go to PULSE.
  - Otherwise, if remaining>=SMALL_VAL and SMALL usable → select SMALL, go to PULSE.
  - Otherwise → DONE.
  - A hopper is usable when its empty input is 0 and its fault bit is 0.
- PULSE: the selected pulse output is registered high for exactly PULSE_CYC cycles, then the block goes to WAIT_ACK with the timer cleared.
- WAIT_ACK:
  - On the selected hopper's ack, the next cycle sets remaining -= coin value, increments the optional counter, and goes to SELECT.
  - If the timer reaches TIMEOUT_CYC first, set the hopper's fault bit, leave remaining unchanged, and go to SELECT.
- Ack handling:
  - An ack from the selected hopper during PULSE is captured; WAIT_ACK is then skipped.
  - Acks from the unselected hopper, or any ack in IDLE, SELECT or DONE, are ignored.
- DONE (1 cycle): done=1, shortfall=remaining, then IDLE.
- Latency: a value-0 request gives done 2 cycles after acceptance.
- Arithmetic: the subtract never underflows because SELECT guarantees remaining >= coin value. Counters saturate at 0xFFFF.
- big_pulse and small_pulse are never high together.
- fault is cleared only by rst.

Optional Feature:
- VM_CHANGE_STATS_EN defined: big_count and small_count count acknowledged coins per hopper, 16-bit saturating, cleared by rst.
- Undefined: the count ports remain but are tied to 0, and the counter logic is omitted.

Decomposition:
- Package vm_change_pkg holds:
  - the state encoding (IDLE, SELECT, PULSE, WAIT_ACK, DONE);
  - the coin-select encoding (COIN_BIG, COIN_SMALL);
  - fault bit indices.
- One sub-module, vm_pulse_timer: a shared counter that provides the PULSE_CYC pulse length and the TIMEOUT_CYC timeout, with start, pulse_active and expired signals.

Test Plan:
- req_value=13, both hoppers stocked, ack 2 cycles after each pulse → pulse order BIG, BIG, SMALL, SMALL, SMALL; done with shortfall=0; fault=00.
- req_value=7, big_empty=1 → 7 SMALL pulses, no BIG pulse, shortfall=0.
- req_value=6, SMALL never acks, TIMEOUT_CYC=20 → one BIG paid, SMALL times out; fault=01, shortfall=1; the next request avoids SMALL.
- req_value=0 → done 2 cycles after accept, no pulses, shortfall=0; req_ready is low for those 2 cycles.
- rst asserted in the 2nd cycle of a BIG pulse → big_pulse=0 the next cycle, req_ready=1, fault=00, counts=0.
- Ack injected during PULSE, plus a stray small_ack while BIG is selected → exactly one BIG decrement, no WAIT_ACK dwell, stray ack ignored. With VM_CHANGE_STATS_EN, big_count increments by 1.
